msrv32_fetch_unit: RTL

//  Instruction fetch stage directly upstream of msrv32_instruction_mux. Owns the PC.

---
 rtl/msrv32_fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/msrv32_fetch_unit.sv
// msrv32_fetch_unit
// Instruction fetch stage. Owns the PC, runs a req/ready handshake with the
// instruction memory, registers the fetched word for the instruction mux and
// handles branch/trap redirects, including discarding a fetch already in flight.
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misaligned_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] discard_addr;
  logic        req_live;
  logic [31:0] redirect_target;

  // Memory-facing outputs decode directly from registered state, so they stay
  // stable for the whole time a request is outstanding.
  assign req_live        = (state == FETCH) || (state == DISCARD);
  assign redirect_target = {redirect_pc_in[31:2], 2'b00};
  assign imem_req_out    = req_live;
  assign imem_addr_out   = (state == DISCARD) ? discard_addr : pc;

  // Fetch sequencer: PC, handshake state and the registered instruction slot.
  // NOTE: all state here is updated with non-blocking assignments so every
  // branch below reads the pre-edge values of pc/state, independent of order.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state           <= IDLE;
      pc              <= BOOT_ADDR;
      discard_addr    <= 32'h0;
      instr_out       <= NOP;
      pc_out          <= 32'h0;
      instr_valid_out <= 1'b0;
      flush_out       <= 1'b1;
      misaligned_out  <= 1'b0;
    end else begin
      // Flush and misalignment are one-cycle echoes of a redirect pulse.
      flush_out      <= redirect_in;
      misaligned_out <= redirect_in & (|redirect_pc_in[1:0]);

      if (redirect_in) begin
        pc              <= redirect_target;
        instr_valid_out <= 1'b0;
        instr_out       <= NOP;
        // A request still waiting for its ack must run to completion at the
        // old address; its data is thrown away in DISCARD.
        if (req_live && !imem_ready_in) begin
          if (state == FETCH) begin
            discard_addr <= pc;
          end
          state <= DISCARD;
        end else begin
          state <= FETCH;
        end
      end else begin
        case (state)
          IDLE: begin
            state <= FETCH;
          end
          FETCH: begin
            if (imem_ready_in) begin
              instr_out       <= imem_rdata_in;
              pc_out          <= pc;
              instr_valid_out <= 1'b1;
              pc              <= pc + 32'd4;
              state           <= HOLD;
            end
          end
          HOLD: begin
            if (instr_valid_out && !stall_in) begin
              instr_valid_out <= 1'b0;
              state           <= FETCH;
            end
          end
          DISCARD: begin
            if (imem_ready_in) begin
              state <= FETCH;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
